// File: rtl/snn_ips_pkg.sv
// Shared definitions for the SNN input-spike generator: FSM states,
// stochastic-mode LFSR constants and the per-channel draw rotation stride.
package snn_ips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ips_state_t;

    // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned ROT_STRIDE = 7;

endpackage

// File: rtl/ips_channel.sv
// One input channel: period down-counter, disable on period 0, and the
// registered spike bit (or the stochastic draw result when rand_en is set).
module ips_channel #(
    parameter int unsigned FW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] period,
    input  logic          clr,
    input  logic          init,
    input  logic          adv,
    input  logic          rand_en,
    input  logic          rand_hit,
    output logic          spike
);

    logic [FW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            spike <= 1'b0;
        end else if (clr) begin
            spike <= 1'b0;
        end else if (init) begin
            cnt   <= (period == '0) ? '0 : period - 1'b1;
            spike <= 1'b0;
        end else if (adv) begin
            if (rand_en) begin
                spike <= rand_hit;
            end else if (period == '0) begin
                spike <= 1'b0;
            end else if (cnt == '0) begin
                spike <= 1'b1;
                cnt   <= period - 1'b1;
            end else begin
                spike <= 1'b0;
                cnt   <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_train_gen.sv
// Input-spike generator: M channels stepped over a TU_LEN-step window.
// Optional stochastic mode is built only when RAND_SPIKE_EN is defined.
module spike_train_gen
    import snn_ips_pkg::*;
#(
    parameter int unsigned M      = 784,
    parameter int unsigned FW     = 8,
    parameter int unsigned TU_LEN = 200,
    parameter int unsigned LFSR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [M*FW-1:0] rf_period_packed,
    input  logic            load,
    input  logic            start,
    input  logic            step,
    input  logic            mode,
    output logic [M-1:0]    spikes,
    output logic            spike_valid,
    output logic            window_done,
    output logic            busy
);

    localparam int unsigned TW = $clog2(TU_LEN + 1);

    ips_state_t      state, state_nx;
    logic [TW-1:0]   tu_cnt;
    logic [M*FW-1:0] period_buf;
    logic            start_acc, step_acc, last_step;
    logic            mode_q;
    logic [M-1:0]    rand_hit;

    // load outranks start, start outranks step
    assign start_acc = start & ~load;
    assign step_acc  = step & ~load & ~start & (state == ST_RUN);
    assign last_step = step_acc & (tu_cnt == TW'(TU_LEN - 1));
    assign busy      = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (load)           state_nx = ST_IDLE;
        else if (start)     state_nx = ST_RUN;
        else if (last_step) state_nx = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tu_cnt      <= '0;
            period_buf  <= '0;
            spike_valid <= 1'b0;
            window_done <= 1'b0;
        end else begin
            spike_valid <= step_acc;
            window_done <= last_step;
            if (load)
                period_buf <= rf_period_packed;
            if (start_acc)
                tu_cnt <= '0;
            else if (step_acc)
                tu_cnt <= tu_cnt + 1'b1;
        end
    end

`ifdef RAND_SPIKE_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= LFSR_W'(LFSR_SEED);
            mode_q <= 1'b0;
        end else if (start_acc) begin
            lfsr   <= LFSR_W'(LFSR_SEED);
            mode_q <= mode;
        end else if (step_acc) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_W'(LFSR_TAPS)) : (lfsr >> 1);
        end
    end

    // each channel draws the low FW bits of the LFSR rotated left by i*7
    for (genvar i = 0; i < M; i++) begin : g_draw
        localparam int unsigned SH = (i * ROT_STRIDE) % LFSR_W;
        assign rand_hit[i] =
            FW'((lfsr << SH) | (lfsr >> (LFSR_W - SH))) < period_buf[FW*i +: FW];
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign mode_q      = 1'b0;
    assign rand_hit    = '0;
`endif

    for (genvar i = 0; i < M; i++) begin : g_ch
        ips_channel #(.FW(FW)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .period   (period_buf[FW*i +: FW]),
            .clr      (load),
            .init     (start_acc),
            .adv      (step_acc),
            .rand_en  (mode_q),
            .rand_hit (rand_hit[i]),
            .spike    (spikes[i])
        );
    end

endmodule

// File: tb/tb_spike_train_gen.sv
// Self-checking bench for spike_train_gen (M=4, FW=8, TU_LEN=10) against a
// closed-form window model: channel i spikes at window step k iff k mod P_i == 0.
module tb_spike_train_gen;

    localparam int M = 4, FW = 8, TU_LEN = 10;
`ifdef RAND_SPIKE_EN
    localparam bit RAND = 1'b1;
`else
    localparam bit RAND = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1, load = 1'b0, start = 1'b0, step = 1'b0, mode = 1'b0;
    logic [M*FW-1:0] rf = '0;
    logic [M-1:0]    spikes;
    logic            spike_valid, window_done, busy;

    always #5 clk = ~clk;

    spike_train_gen #(.M(M), .FW(FW), .TU_LEN(TU_LEN), .LFSR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .rf_period_packed (rf),
        .load             (load),
        .start            (start),
        .step             (step),
        .mode             (mode),
        .spikes           (spikes),
        .spike_valid      (spike_valid),
        .window_done      (window_done),
        .busy             (busy)
    );

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: window state (0 idle, 1 run, 2 done), steps taken, period buffer
    int         st = 0, tu = 0;
    int         pbuf[M];
    logic       win_rand = 1'b0;
    logic [M-1:0] e_spk = '0;
    logic       e_valid = 1'b0, e_done = 1'b0, e_busy = 1'b0;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (rst) begin
            st = 0; tu = 0; e_spk = '0; win_rand = 1'b0;
            for (int i = 0; i < M; i++) pbuf[i] = 0;
        end else if (load) begin
            for (int i = 0; i < M; i++) pbuf[i] = int'(rf[FW*i +: FW]);
            st = 0; e_spk = '0;
        end else if (start) begin
            st = 1; tu = 0; e_spk = '0; win_rand = RAND && mode;
        end else if (step && st == 1) begin
            tu++;
            for (int i = 0; i < M; i++)
                e_spk[i] = (pbuf[i] != 0) && (tu % pbuf[i] == 0);
            e_valid = 1'b1;
            if (tu == TU_LEN) begin
                e_done = 1'b1;
                st = 2;
            end
        end
        e_busy = (st == 1);
    end

    int ch_cnt[M];
    int valid_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("spike_valid", spike_valid, e_valid);
            chk("window_done", window_done, e_done);
            if (!win_rand) chk("spikes", spikes, e_spk);
            if (spike_valid) begin
                valid_cnt++;
                for (int i = 0; i < M; i++) ch_cnt[i] += int'(spikes[i]);
            end
            if (window_done) done_cnt++;
        end
    end

    task automatic drive(input logic r, input logic l, input logic s, input logic t);
        @(negedge clk);
        #1;
        rst = r; load = l; start = s; step = t;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < M; i++) ch_cnt[i] = 0;
        valid_cnt = 0;
        done_cnt  = 0;
    endtask

    // drive one accepted step and look at the registered result
    task automatic step_look(output logic [M-1:0] s, output logic v, output logic d);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        s = spikes; v = spike_valid; d = window_done;
    endtask

    logic [M-1:0] s;
    logic         v, d;

    initial begin
        clr_counts();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_spikes", spikes, 0);
        chk("rst_busy", busy, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // periods {1,2,3,0}, full window with random gaps between steps
        rf = {8'd0, 8'd3, 8'd2, 8'd1};
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        clr_counts();
        for (int k = 1; k <= TU_LEN; k++) begin
            step_look(s, v, d);
            if (k == 1)  chk("step1_spikes", s, 4'b0001);
            if (k == 6)  chk("step6_spikes", s, 4'b0111);
            if (k == 10) chk("step10_done", d, 1);
            repeat ($urandom_range(0, 2)) idle();
        end
        idle(); idle();
        chk("cnt_ch0", ch_cnt[0], 10);
        chk("cnt_ch1", ch_cnt[1], 5);
        chk("cnt_ch2", ch_cnt[2], 3);
        chk("cnt_ch3", ch_cnt[3], 0);
        chk("done_cnt", done_cnt, 1);

        // steps in DONE are ignored; restart replays the pattern
        clr_counts();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        chk("done_steps_ignored", valid_cnt, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step_look(s, v, d);
        chk("restart_step1", s, 4'b0001);
        step_look(s, v, d);
        chk("restart_step2", s, 4'b0011);

        // start with step: step dropped, then abort with load at step 4
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("start_step_valid", spike_valid, 0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", window_done, 0);
        step_look(s, v, d);
        chk("abort_step_valid", v, 0);

        // reset together with a step mid-window clears the period buffer
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_mid_out", {spikes, spike_valid, window_done, busy}, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step_look(s, v, d);
        chk("zero_buf_spikes", s, 0);
        chk("zero_buf_valid", v, 1);

        // back-to-back steps over a full window
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        clr_counts();
        repeat (TU_LEN) drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        chk("b2b_valid_cnt", valid_cnt, 10);
        chk("b2b_done_cnt", done_cnt, 1);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic r, l, st_i, sp;
            r    = ($urandom_range(0, 149) == 0);
            l    = ($urandom_range(0, 24) == 0);
            st_i = ($urandom_range(0, 14) == 0);
            sp   = ($urandom_range(0, 2) != 0);
            if (l)
                for (int i = 0; i < M; i++)
                    rf[FW*i +: FW] = FW'($urandom_range(0, 5));
            drive(r, l, st_i, sp);
        end
        idle(); idle();

`ifdef RAND_SPIKE_EN
        begin
            logic [M-1:0] first_seq[TU_LEN];
            int c1 = 0, c2 = 0, c03 = 0;
            rf = {8'd0, 8'd128, 8'd255, 8'd0};
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            for (int w = 0; w < 100; w++) begin
                mode = 1'b1;
                drive(1'b0, 1'b0, 1'b1, 1'b0);
                mode = 1'b0;
                for (int k = 0; k < TU_LEN; k++) begin
                    step_look(s, v, d);
                    c1  += int'(s[1]);
                    c2  += int'(s[2]);
                    c03 += int'(s[0] | s[3]);
                    if (w == 0) first_seq[k] = s;
                    else if (s !== first_seq[k]) chk("rand_repeat", s, first_seq[k]);
                end
            end
            idle(); idle();
            chk("rand_ch03_never", c03, 0);
            chk("rand_ch1_ge99", (c1 >= 990), 1);
            chk("rand_ch2_40_60", (c2 >= 400 && c2 <= 600), 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
